noc_xy_router: RTL and testbench

Parametrised five-port 2D-mesh NoC router with dimension-ordered (X then Y) routing, per-input FIFO buffering, valid/ready handshakes and per-output round-robin arbitration. One instance sits at each mesh node between the four neighbour links and the local network interface. Unlike the earlier fixed 18-bit, time-sliced router, it serves all five ports concurrently and applies backpressure instead of overwriting outputs.

---
 rtl/noc_pkg.sv | 65 ++++++
 rtl/noc_flit_fifo.sv | 52 +++++
 rtl/noc_xy_router.sv | 167 ++++++++++++++++
 tb/tb_noc_xy_router.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and helpers for the XY mesh router: port indices, flit field
// extraction and dimension-ordered route selection.
package noc_pkg;

   localparam int unsigned NUM_PORTS   = 5;
   localparam int unsigned PORT_IDX_W  = 3;
   localparam int unsigned CNT_W       = 16;
   localparam int unsigned MAX_COORD_W = 16;
   localparam int unsigned MAX_FLIT_W  = 128;

   typedef enum logic [PORT_IDX_W-1:0] {
      PORT_L = 3'd0,
      PORT_W = 3'd1,
      PORT_E = 3'd2,
      PORT_N = 3'd3,
      PORT_S = 3'd4
   } port_e;

   function automatic logic [MAX_COORD_W-1:0] coord_mask(input int unsigned coord_w);
      logic [MAX_COORD_W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < MAX_COORD_W; b++) begin
         if (b < coord_w) m[b] = 1'b1;
      end
      return m;
   endfunction

   // Flits are {dst_x, dst_y, payload}; callers zero-extend to MAX_FLIT_W.
   function automatic logic [MAX_COORD_W-1:0] flit_dst_x(input logic [MAX_FLIT_W-1:0] flit,
                                                         input int unsigned coord_w,
                                                         input int unsigned payload_w);
      return MAX_COORD_W'(flit >> (coord_w + payload_w)) & coord_mask(coord_w);
   endfunction

   function automatic logic [MAX_COORD_W-1:0] flit_dst_y(input logic [MAX_FLIT_W-1:0] flit,
                                                         input int unsigned coord_w,
                                                         input int unsigned payload_w);
      return MAX_COORD_W'(flit >> payload_w) & coord_mask(coord_w);
   endfunction

   function automatic logic [MAX_FLIT_W-1:0] flit_payload(input logic [MAX_FLIT_W-1:0] flit,
                                                          input int unsigned payload_w);
      logic [MAX_FLIT_W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < MAX_FLIT_W; b++) begin
         if (b < payload_w) m[b] = 1'b1;
      end
      return flit & m;
   endfunction

   // X is resolved completely before Y.
   function automatic port_e xy_route(input logic [MAX_COORD_W-1:0] dst_x,
                                      input logic [MAX_COORD_W-1:0] dst_y,
                                      input logic [MAX_COORD_W-1:0] my_x,
                                      input logic [MAX_COORD_W-1:0] my_y);
      port_e p;
      if (dst_x > my_x)      p = PORT_E;
      else if (dst_x < my_x) p = PORT_W;
      else if (dst_y > my_y) p = PORT_N;
      else if (dst_y < my_y) p = PORT_S;
      else                   p = PORT_L;
      return p;
   endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with full/empty flags and a combinational head.
// Depth must be a power of two so the pointers wrap naturally.
module noc_flit_fifo #(
   parameter int unsigned FLIT_W     = 18,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [FLIT_W-1:0] push_data,
   input  logic              pop,
   output logic [FLIT_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin : ctrl_c
      full     = (count_q == CW'(FIFO_DEPTH));
      empty    = (count_q == '0);
      do_push  = push && !full && !rst;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (rst) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/noc_xy_router.sv
// Five-port XY mesh router: per-input FIFOs, round-robin output arbitration,
// registered outputs with backpressure. Statistics counters exist only when
// NOC_ROUTER_STATS_EN is defined; otherwise the stat ports read as zero.
module noc_xy_router
   import noc_pkg::*;
#(
   parameter  int unsigned COORD_W    = 2,
   parameter  int unsigned PAYLOAD_W  = 14,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned FLIT_W     = 2 * COORD_W + PAYLOAD_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [COORD_W-1:0]                  my_x,
   input  logic [COORD_W-1:0]                  my_y,
   input  logic [NUM_PORTS-1:0][FLIT_W-1:0]    in_flit,
   input  logic [NUM_PORTS-1:0]                in_valid,
   output logic [NUM_PORTS-1:0]                in_ready,
   output logic [NUM_PORTS-1:0][FLIT_W-1:0]    out_flit,
   output logic [NUM_PORTS-1:0]                out_valid,
   input  logic [NUM_PORTS-1:0]                out_ready,
   output logic [NUM_PORTS-1:0][CNT_W-1:0]     stat_fwd_cnt,
   output logic [CNT_W-1:0]                    stat_drop_cnt
);

   logic [COORD_W-1:0]                    my_x_q, my_x_d, my_y_q, my_y_d;
   logic [NUM_PORTS-1:0][FLIT_W-1:0]      fifo_head;
   logic [NUM_PORTS-1:0]                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]  route_idx;
   logic [NUM_PORTS-1:0]                  head_drop;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   req;      // req[output][input]
   logic [NUM_PORTS-1:0]                  grant_vld;
   logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]  grant_idx;
   logic [PORT_IDX_W-1:0]                 cand;
   logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]  rr_q, rr_d;
   logic [NUM_PORTS-1:0]                  out_valid_q, out_valid_d;
   logic [NUM_PORTS-1:0][FLIT_W-1:0]      out_flit_q, out_flit_d;

   // Node coordinates are captured only while reset is held.
   always_comb begin : coord_c
      my_x_d = my_x_q;
      my_y_d = my_y_q;
      if (rst) begin
         my_x_d = my_x;
         my_y_d = my_y;
      end
   end

   assign in_ready  = ~fifo_full & {NUM_PORTS{~rst}};
   assign fifo_push = in_valid & in_ready;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
      noc_flit_fifo #(
         .FLIT_W     (FLIT_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (fifo_push[gi]),
         .push_data (in_flit[gi]),
         .pop       (fifo_pop[gi]),
         .head      (fifo_head[gi]),
         .full      (fifo_full[gi]),
         .empty     (fifo_empty[gi])
      );
   end

   // Route every head; a non-local head routed back to its arrival port is a U-turn.
   always_comb begin : route_c
      route_idx = '0;
      head_drop = '0;
      req       = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         route_idx[i] = PORT_IDX_W'(xy_route(
            flit_dst_x(MAX_FLIT_W'(fifo_head[i]), COORD_W, PAYLOAD_W),
            flit_dst_y(MAX_FLIT_W'(fifo_head[i]), COORD_W, PAYLOAD_W),
            MAX_COORD_W'(my_x_q),
            MAX_COORD_W'(my_y_q)));
         head_drop[i] = !fifo_empty[i] && (i != 0) && (route_idx[i] == PORT_IDX_W'(i));
         for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            req[o][i] = !fifo_empty[i] && !head_drop[i] && (route_idx[i] == PORT_IDX_W'(o));
         end
      end
   end

   // Per-output round-robin; an occupied output register may reload as it drains.
   always_comb begin : arb_c
      grant_vld   = '0;
      grant_idx   = '0;
      cand        = '0;
      rr_d        = rr_q;
      out_valid_d = out_valid_q;
      out_flit_d  = out_flit_q;
      fifo_pop    = head_drop;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
         if (!out_valid_q[o] || out_ready[o]) begin
            out_valid_d[o] = 1'b0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
               cand = PORT_IDX_W'((32'(rr_q[o]) + k) % NUM_PORTS);
               if (!grant_vld[o] && req[o][cand]) begin
                  grant_vld[o] = 1'b1;
                  grant_idx[o] = cand;
               end
            end
            if (grant_vld[o]) begin
               out_valid_d[o]          = 1'b1;
               out_flit_d[o]           = fifo_head[grant_idx[o]];
               fifo_pop[grant_idx[o]]  = 1'b1;
               rr_d[o] = (grant_idx[o] == PORT_IDX_W'(NUM_PORTS - 1)) ? '0
                                                                       : grant_idx[o] + PORT_IDX_W'(1);
            end
         end
      end
      if (rst) begin
         rr_d        = '0;
         out_valid_d = '0;
         out_flit_d  = '0;
         fifo_pop    = '0;
      end
   end

   always_ff @(posedge clk) begin
      my_x_q      <= my_x_d;
      my_y_q      <= my_y_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
   end

   assign out_valid = out_valid_q;
   assign out_flit  = out_flit_q;

`ifdef NOC_ROUTER_STATS_EN
   logic [NUM_PORTS-1:0][CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
   logic [CNT_W-1:0]                drop_cnt_q, drop_cnt_d;

   // Saturating counters; several U-turns may be dropped in one cycle.
   always_comb begin : stats_c
      fwd_cnt_d  = fwd_cnt_q;
      drop_cnt_d = drop_cnt_q;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
         if (out_valid_q[o] && out_ready[o] && (fwd_cnt_q[o] != '1))
            fwd_cnt_d[o] = fwd_cnt_q[o] + CNT_W'(1);
      end
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (head_drop[i] && (drop_cnt_d != '1))
            drop_cnt_d = drop_cnt_d + CNT_W'(1);
      end
      if (rst) begin
         fwd_cnt_d  = '0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
   end

   assign stat_fwd_cnt  = fwd_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
`else
   assign stat_fwd_cnt  = '0;
   assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_xy_router.sv
// Randomised bench for noc_xy_router against a queue-based reference model
// of the router's transfer rules.
module tb_noc_xy_router;

   localparam int unsigned COORD_W    = 2;
   localparam int unsigned PAYLOAD_W  = 14;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FLIT_W     = 2 * COORD_W + PAYLOAD_W;
   localparam int unsigned NP         = 5;
   localparam int          NCYC       = 5000;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [COORD_W-1:0]           my_x, my_y;
   logic [NP-1:0][FLIT_W-1:0]    in_flit, out_flit;
   logic [NP-1:0]                in_valid, in_ready, out_valid, out_ready;
   logic [NP-1:0][15:0]          stat_fwd_cnt;
   logic [15:0]                  stat_drop_cnt;

   always #5 clk = ~clk;

   noc_xy_router #(
      .COORD_W    (COORD_W),
      .PAYLOAD_W  (PAYLOAD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .my_x          (my_x),
      .my_y          (my_y),
      .in_flit       (in_flit),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_flit      (out_flit),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .stat_fwd_cnt  (stat_fwd_cnt),
      .stat_drop_cnt (stat_drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state: buffered flits per input, output registers, pointers, counts.
   logic [FLIT_W-1:0] mq [NP][$];
   bit                m_ov [NP];
   logic [FLIT_W-1:0] m_of [NP];
   int                m_rr [NP];
   int                m_fwd [NP];
   int                m_drop;
   int                m_mx, m_my;

   function automatic int route_of(input int dx, input int dy, input int mx, input int my);
      if (dx != mx) return (dx > mx) ? 2 : 1;
      if (dy != my) return (dy > my) ? 3 : 4;
      return 0;
   endfunction

   task automatic model_step();
      bit  hv [NP];
      bit  dr [NP];
      bit  popf [NP];
      bit  acc [NP];
      int  rt [NP];
      logic [FLIT_W-1:0] h;
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            m_ov[i]  = 1'b0;
            m_of[i]  = '0;
            m_rr[i]  = 0;
            m_fwd[i] = 0;
         end
         m_drop = 0;
         m_mx   = int'(my_x);
         m_my   = int'(my_y);
         return;
      end
      for (int i = 0; i < NP; i++) begin
         hv[i]   = mq[i].size() > 0;
         rt[i]   = -1;
         dr[i]   = 1'b0;
         popf[i] = 1'b0;
         if (hv[i]) begin
            h     = mq[i][0];
            rt[i] = route_of(int'(h[FLIT_W-1 -: COORD_W]), int'(h[PAYLOAD_W +: COORD_W]), m_mx, m_my);
            dr[i] = (i != 0) && (rt[i] == i);
         end
         acc[i] = in_valid[i] && (mq[i].size() < FIFO_DEPTH);
      end
      for (int o = 0; o < NP; o++) begin
         bit gv;
         int gi;
         gv = 1'b0;
         gi = 0;
         if (m_ov[o] && out_ready[o] && m_fwd[o] < 65535) m_fwd[o]++;
         if (!m_ov[o] || out_ready[o]) begin
            for (int k = 0; k < NP; k++) begin
               int c;
               c = (m_rr[o] + k) % NP;
               if (!gv && hv[c] && !dr[c] && rt[c] == o) begin
                  gv = 1'b1;
                  gi = c;
               end
            end
            if (gv) begin
               m_ov[o]  = 1'b1;
               m_of[o]  = mq[gi][0];
               popf[gi] = 1'b1;
               m_rr[o]  = (gi + 1) % NP;
            end else begin
               m_ov[o] = 1'b0;
            end
         end
      end
      for (int i = 0; i < NP; i++) begin
         if (dr[i]) begin
            popf[i] = 1'b1;
            if (m_drop < 65535) m_drop++;
         end
         if (popf[i]) void'(mq[i].pop_front());
         if (acc[i]) mq[i].push_back(in_flit[i]);
      end
   endtask

   task automatic compare();
      logic [NP-1:0][FLIT_W-1:0] ef;
      logic [NP-1:0]             ev, er;
      logic [NP-1:0][15:0]       efc;
      logic [15:0]               edc;
      for (int i = 0; i < NP; i++) begin
         ev[i]  = m_ov[i];
         ef[i]  = m_of[i];
         er[i]  = !rst && (mq[i].size() < FIFO_DEPTH);
`ifdef NOC_ROUTER_STATS_EN
         efc[i] = 16'(m_fwd[i]);
`else
         efc[i] = '0;
`endif
      end
`ifdef NOC_ROUTER_STATS_EN
      edc = 16'(m_drop);
`else
      edc = '0;
`endif
      check("in_ready",  128'(in_ready),      128'(er));
      check("out_valid", 128'(out_valid),     128'(ev));
      check("out_flit",  128'(out_flit),      128'(ef));
      check("fwd_cnt",   128'(stat_fwd_cnt),  128'(efc));
      check("drop_cnt",  128'(stat_drop_cnt), 128'(edc));
   endtask

   // Phases: light load, heavy backpressure, wandering coordinates,
   // single-source stream into a stalled E output, all-to-E contention.
   task automatic drive(input int cyc);
      int phase, vp, rp;
      phase = cyc / 1000;
      rst   = ((cyc % 1000) < 2) || ($urandom_range(0, 249) == 0);
      case (phase)
         0:       begin vp = 50;  rp = 90;  end
         1:       begin vp = 70;  rp = 30;  end
         2:       begin vp = 60;  rp = 60;  end
         default: begin vp = 100; rp = 100; end
      endcase
      my_x = 2'd1;
      my_y = 2'd1;
      if (phase == 2) begin
         my_x = 2'($urandom_range(0, 3));
         my_y = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < NP; i++) begin
         in_valid[i]  = $urandom_range(0, 99) < vp;
         in_flit[i]   = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 14'($urandom)};
         out_ready[i] = $urandom_range(0, 99) < rp;
         if (phase == 3) begin
            in_valid[i] = (i == 1) && ($urandom_range(0, 99) < 80);
            in_flit[i]  = {2'd3, 2'($urandom_range(0, 3)), 14'(cyc)};
            out_ready[i] = (i == 2) ? (((cyc / 16) % 2) == 1) : 1'b1;
         end
         if (phase == 4) in_flit[i] = {2'd3, 2'($urandom_range(0, 3)), 14'($urandom)};
      end
   endtask

   initial begin
      rst       = 1'b1;
      my_x      = 2'd1;
      my_y      = 2'd1;
      in_valid  = '0;
      in_flit   = '0;
      out_ready = '1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         drive(cyc);
         #1;
         if (cyc > 0) compare();
         model_step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
